// File: rtl/dwc_axil_pkg.sv
// Shared definitions for the DWC AXI4-Lite register block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dwc_axil_pkg;

    // Byte offsets of the register map
    localparam logic [7:0] OFS_CTRL    = 8'h00;
    localparam logic [7:0] OFS_RES_A   = 8'h04;
    localparam logic [7:0] OFS_RES_B   = 8'h08;
    localparam logic [7:0] OFS_SCRATCH = 8'h0C;
    localparam logic [7:0] OFS_MISCNT  = 8'h10;
    localparam logic [7:0] OFS_STATUS  = 8'h14;

    // Word slot index decoded from addr[4:2]
    typedef logic [2:0] slot_t;

    localparam slot_t SLOT_CTRL    = OFS_CTRL[4:2];
    localparam slot_t SLOT_RES_A   = OFS_RES_A[4:2];
    localparam slot_t SLOT_RES_B   = OFS_RES_B[4:2];
    localparam slot_t SLOT_SCRATCH = OFS_SCRATCH[4:2];
    localparam slot_t SLOT_MISCNT  = OFS_MISCNT[4:2];
    localparam slot_t SLOT_STATUS  = OFS_STATUS[4:2];

    // CTRL bit positions
    localparam int CTRL_CMP_EN = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_MISMATCH = 0;
    localparam int STAT_LAST_EQ  = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write channel states: RST keeps READYs low for the cycle after reset
    typedef enum logic [2:0] {
        WR_RST,
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_BOTH,
        WR_RESP
    } wr_state_t;

    // Read channel states
    typedef enum logic [1:0] {
        RD_RST,
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    // Byte-lane merge of write data onto the current register value
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dwc_axil_regs_cmp.sv
// Compares RES_A against the freshly written RES_B; keeps a saturating mismatch count and sticky flag.
// Latency: results registered on the edge that carries cmp_vld / clr_vld.
// Backpressure: none; accepts one strobe per cycle, clear wins over compare.
module dwc_cmp_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmp_vld,
    input  logic                 clr_vld,
    input  logic [31:0]          res_a,
    input  logic [31:0]          res_b,
    output logic [CNT_WIDTH-1:0] miscnt,
    output logic                 mismatch,
    output logic                 last_eq
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Clear, then compare event: unequal bumps the count and sets the sticky flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miscnt   <= '0;
            mismatch <= 1'b0;
            last_eq  <= 1'b0;
        end else if (clr_vld) begin
            miscnt   <= '0;
            mismatch <= 1'b0;
            last_eq  <= 1'b0;
        end else if (cmp_vld) begin
            if (res_a != res_b) begin
                mismatch <= 1'b1;
                last_eq  <= 1'b0;
                if (miscnt != CNT_MAX) miscnt <= miscnt + 1'b1;
            end else begin
                last_eq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dwc_axil_regs.sv
// AXI4-Lite register block for the DWC IP: result registers, compare control, status.
// Latency: write response 1 cycle after the later of AW/W; read data 1 cycle after AR.
// Backpressure: single outstanding write and read; READYs drop while a response is held.
module dwc_axil_regs
    import dwc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            mismatch_o,
    output logic                            irq_o
);

    // Protection bits and byte offset within the word carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic        aw_rdy, w_rdy, ar_rdy;
    slot_t       aw_slot;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic [1:0]  bresp_q;

    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        ctrl_cmp_en, ctrl_irq_en;
    logic [31:0] res_a, res_b, scratch;

    logic [CNT_WIDTH-1:0] miscnt;
    logic                 mismatch, last_eq;
    logic [31:0]          miscnt_ext;

    logic        wr_commit;
    logic [1:0]  wr_resp;
    logic [31:0] wr_cur_val, wr_merged;
    logic        cmp_vld, clr_vld;

    slot_t       ar_slot;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;

    // Write channel state register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) wr_state <= WR_RST;
        else          wr_state <= wr_next;
    end

    // Write channel next state and READY decode; AW and W accepted in any order
    always_comb begin
        wr_next = wr_state;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        case (wr_state)
            WR_RST:  wr_next = WR_IDLE;
            WR_IDLE: begin
                aw_rdy = 1'b1;
                w_rdy  = 1'b1;
                if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = WR_BOTH;
                else if (S_AXI_AWVALID)            wr_next = WR_ADDR;
                else if (S_AXI_WVALID)             wr_next = WR_DATA;
            end
            WR_ADDR: begin
                w_rdy = 1'b1;
                if (S_AXI_WVALID) wr_next = WR_BOTH;
            end
            WR_DATA: begin
                aw_rdy = 1'b1;
                if (S_AXI_AWVALID) wr_next = WR_BOTH;
            end
            WR_BOTH: wr_next = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Latch address and data on their handshakes
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_slot <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (aw_rdy && S_AXI_AWVALID) aw_slot <= S_AXI_AWADDR[4:2];
            if (w_rdy && S_AXI_WVALID) begin
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
        end
    end

    assign wr_commit = (wr_state == WR_BOTH);

    // Write decode: response code, current value for the byte merge
    always_comb begin
        wr_resp    = RESP_OKAY;
        wr_cur_val = '0;
        case (aw_slot)
            SLOT_CTRL:    wr_cur_val = {29'b0, ctrl_irq_en, 1'b0, ctrl_cmp_en};
            SLOT_RES_A:   wr_cur_val = res_a;
            SLOT_RES_B:   wr_cur_val = res_b;
            SLOT_SCRATCH: wr_cur_val = scratch;
            SLOT_MISCNT,
            SLOT_STATUS:  wr_resp = RESP_SLVERR;
            default:      wr_resp = RESP_DECERR;
        endcase
        wr_merged = strb_merge(wr_cur_val, w_data, w_strb);
    end

    // Compare fires on a RES_B commit while enabled; clr pulses on a CTRL commit
    assign cmp_vld = wr_commit && (aw_slot == SLOT_RES_B) && ctrl_cmp_en;
    assign clr_vld = wr_commit && (aw_slot == SLOT_CTRL) && wr_merged[CTRL_CLR];

    // Register file update on commit; error slots leave state untouched
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ctrl_cmp_en <= 1'b0;
            ctrl_irq_en <= 1'b0;
            res_a       <= '0;
            res_b       <= '0;
            scratch     <= '0;
        end else if (wr_commit && (wr_resp == RESP_OKAY)) begin
            case (aw_slot)
                SLOT_CTRL: begin
                    ctrl_cmp_en <= wr_merged[CTRL_CMP_EN];
                    ctrl_irq_en <= wr_merged[CTRL_IRQ_EN];
                end
                SLOT_RES_A:   res_a   <= wr_merged;
                SLOT_RES_B:   res_b   <= wr_merged;
                SLOT_SCRATCH: scratch <= wr_merged;
                default: ;
            endcase
        end
    end

    // Write response code captured with BVALID rising, held until BREADY
    always_ff @(posedge ACLK) begin
        if (!ARESETN)       bresp_q <= RESP_OKAY;
        else if (wr_commit) bresp_q <= wr_resp;
    end

    dwc_cmp_unit #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cmp (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .cmp_vld  (cmp_vld),
        .clr_vld  (clr_vld),
        .res_a    (res_a),
        .res_b    (wr_merged),
        .miscnt   (miscnt),
        .mismatch (mismatch),
        .last_eq  (last_eq)
    );

    // Zero-extend the counter to the bus width
    always_comb begin
        miscnt_ext                = '0;
        miscnt_ext[CNT_WIDTH-1:0] = miscnt;
    end

    // Read channel state register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) rd_state <= RD_RST;
        else          rd_state <= rd_next;
    end

    // Read channel next state; ARREADY only while no response is held
    always_comb begin
        rd_next = rd_state;
        ar_rdy  = 1'b0;
        case (rd_state)
            RD_RST:  rd_next = RD_IDLE;
            RD_IDLE: begin
                ar_rdy = 1'b1;
                if (S_AXI_ARVALID) rd_next = RD_RESP;
            end
            RD_RESP: if (S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    assign ar_slot = S_AXI_ARADDR[4:2];

    // Read mux over current register values (pre-write on a coinciding commit)
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (ar_slot)
            SLOT_CTRL:    rd_val = {29'b0, ctrl_irq_en, 1'b0, ctrl_cmp_en};
            SLOT_RES_A:   rd_val = res_a;
            SLOT_RES_B:   rd_val = res_b;
            SLOT_SCRATCH: rd_val = scratch;
            SLOT_MISCNT:  rd_val = miscnt_ext;
            SLOT_STATUS:  rd_val = {30'b0, last_eq, mismatch};
            default:      rd_resp = RESP_DECERR;
        endcase
    end

    // Read data registered on the AR handshake and held through RVALID
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_rdy && S_AXI_ARVALID) begin
            rdata_q <= rd_val;
            rresp_q <= rd_resp;
        end
    end

    assign S_AXI_AWREADY = aw_rdy;
    assign S_AXI_WREADY  = w_rdy;
    assign S_AXI_BVALID  = (wr_state == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_rdy;
    assign S_AXI_RVALID  = (rd_state == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign mismatch_o = mismatch;
    assign irq_o      = mismatch && ctrl_irq_en;

endmodule

// File: tb/tb_dwc_axil_regs.sv
module tb_dwc_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        mismatch_o, irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Small counter width so saturation is reachable
    dwc_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .CNT_WIDTH          (2)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .mismatch_o    (mismatch_o),
        .irq_o         (irq_o)
    );

    // Full write; with hold_b the task returns while BVALID is still pending
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit hold_b,
                             output logic [1:0] resp);
        bit aw_done, w_done;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        bready = !hold_b;
        while (!(aw_done && w_done) && n < 20) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready)   w_done  = 1;
            @(negedge clk);
            if (aw_done) awvalid = 1'b0;
            if (w_done)  wvalid  = 1'b0;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout addr=%h bvalid=%b required=1", addr, bvalid);
        end
        resp = bresp;
        if (!hold_b) begin
            @(negedge clk);
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done;
        int n;
        done = 0; n = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!done && n < 20) begin
            if (arready) done = 1;
            @(negedge clk);
            if (done) arvalid = 1'b0;
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout addr=%h rvalid=%b required=1", addr, rvalid);
        end
        data = rdata;
        resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake got=%b required=00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        checks++;
        if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL reset_data rdata=%h bresp=%b rresp=%b required=0", rdata, bresp, rresp);
        end
        checks++;
        if (mismatch_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags mismatch=%b irq=%b required=0/0", mismatch_o, irq_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset got=%b required=111", {awready, wready, arready});
        end
    endtask

    task automatic test_rw_basic();
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] exp_val [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
        logic [31:0] wr_val  [4] = '{32'h1, 32'h2, 32'h3, 32'h4};
        for (int i = 0; i < 4; i++) begin
            axi_write(5'(4*i), wr_val[i], 4'hF, 1'b0, r);
            checks++;
            if (r !== 2'b00) begin
                errors++;
                $display("FAIL basic_bresp slot=%0d got=%b required=00", i, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4*i), d, r);
            checks++;
            if (d !== exp_val[i] || r !== 2'b00) begin
                errors++;
                $display("FAIL basic_read slot=%0d got=%h/%b required=%h/00", i, d, r, exp_val[i]);
            end
        end
        // cmp_en was set, so RES_B=3 against RES_A=2 counted a mismatch
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL basic_miscnt got=%h required=00000001", d);
        end
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h1 || mismatch_o !== 1'b1 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got=%h mis=%b irq=%b required=00000001/1/0", d, mismatch_o, irq_o);
        end
    endtask

    task automatic test_compare();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h00, 32'h6, 4'hF, 1'b0, r);
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL cmp_preclear status=%h irq=%b required=00000000/0", d, irq_o);
        end
        axi_write(5'h00, 32'h5, 4'hF, 1'b0, r);
        axi_write(5'h04, 32'hDEADBEEF, 4'hF, 1'b0, r);
        axi_write(5'h08, 32'hDEADBEEE, 4'hF, 1'b0, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL cmp_miscnt got=%h required=00000001", d);
        end
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h1 || mismatch_o !== 1'b1 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL cmp_unequal status=%h mis=%b irq=%b required=00000001/1/1", d, mismatch_o, irq_o);
        end
        axi_write(5'h08, 32'hDEADBEEF, 4'hF, 1'b0, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL cmp_equal_miscnt got=%h required=00000001", d);
        end
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL cmp_equal_status got=%h required=00000003", d);
        end
    endtask

    task automatic test_clear();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h00, 32'h3, 4'hF, 1'b0, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clr_miscnt got=%h required=00000000", d);
        end
        axi_read(5'h14, d, r);
        checks++;
        if (d !== 32'h0 || mismatch_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_status got=%h mis=%b irq=%b required=00000000/0/0", d, mismatch_o, irq_o);
        end
        axi_read(5'h00, d, r);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL clr_ctrl_read got=%h required=00000001", d);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h08, 32'h0, 4'hF, 1'b0, r);
        axi_write(5'h10, 32'h12, 4'hF, 1'b0, r);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL err_miscnt_bresp got=%b required=10", r);
        end
        axi_write(5'h14, 32'hFF, 4'hF, 1'b0, r);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL err_status_bresp got=%b required=10", r);
        end
        axi_write(5'h18, 32'hFF, 4'hF, 1'b0, r);
        checks++;
        if (r !== 2'b11) begin
            errors++;
            $display("FAIL err_unmapped_bresp got=%b required=11", r);
        end
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h1 || r !== 2'b00) begin
            errors++;
            $display("FAIL err_miscnt_kept got=%h/%b required=00000001/00", d, r);
        end
        axi_read(5'h18, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b11) begin
            errors++;
            $display("FAIL err_read_18 got=%h/%b required=00000000/11", d, r);
        end
        axi_read(5'h1C, d, r);
        checks++;
        if (d !== 32'h0 || r !== 2'b11) begin
            errors++;
            $display("FAIL err_read_1c got=%h/%b required=00000000/11", d, r);
        end
    endtask

    task automatic test_saturate();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h00, 32'h7, 4'hF, 1'b0, r);
        axi_write(5'h04, 32'h0, 4'hF, 1'b0, r);
        for (int i = 0; i < 3; i++) axi_write(5'h08, 32'h1, 4'hF, 1'b0, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL sat_reach got=%h required=00000003", d);
        end
        axi_write(5'h08, 32'h1, 4'hF, 1'b0, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL sat_hold got=%h required=00000003", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  r;
        logic [31:0] d;
        int n;
        axi_write(5'h0C, 32'h11223344, 4'hF, 1'b0, r);
        @(negedge clk);
        wdata = 32'hAABBCCDD; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!wready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0) begin
                errors++;
                $display("FAIL w_first_wait cyc=%0d wready=%b bvalid=%b required=0/0", i, wready, bvalid);
            end
            @(negedge clk);
        end
        awaddr = 5'h0C; awvalid = 1'b1;
        checks++;
        if (awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_after_w awready=%b required=1", awready);
        end
        @(negedge clk);
        awvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold cyc=%0d bvalid=%b bresp=%b awready=%b wready=%b required=1/00/0/0",
                         i, bvalid, bresp, awready, wready);
            end
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL b_release bvalid=%b awready=%b wready=%b required=0/1/1", bvalid, awready, wready);
        end
        axi_read(5'h0C, d, r);
        checks++;
        if (d !== 32'h1122CCDD) begin
            errors++;
            $display("FAIL strb_merge got=%h required=1122ccdd", d);
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(5'h00, 32'h7, 4'hF, 1'b0, r);
        axi_write(5'h00, 32'h5, 4'hF, 1'b0, r);
        axi_write(5'h04, 32'h1, 4'hF, 1'b0, r);
        axi_write(5'h08, 32'h2, 4'hF, 1'b0, r);
        axi_write(5'h08, 32'h3, 4'hF, 1'b0, r);
        axi_read(5'h10, d, r);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL pre_reset_miscnt got=%h required=00000002", d);
        end
        axi_write(5'h0C, 32'h55, 4'hF, 1'b1, r);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bvalid !== 1'b0 || mismatch_o !== 1'b0 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_flags bvalid=%b mis=%b irq=%b required=0/0/0", bvalid, mismatch_o, irq_o);
        end
        for (int i = 0; i < 6; i++) begin
            axi_read(5'(4*i), d, r);
            checks++;
            if (d !== 32'h0 || r !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_read slot=%0d got=%h/%b required=00000000/00", i, d, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rw_basic();
        test_compare();
        test_clear();
        test_errors();
        test_saturate();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwc_axil_regs.md
Name: dwc_axil_regs

Overview:
- AXI4-Lite slave (responder) register block for the duplication-with-comparison (DWC) IP.
- The AXI VIP master, or a processor core, writes two redundant core results (A and B). The block compares them, counts mismatches and raises a sticky fault flag/interrupt.
- Sits behind the S00_AXI port of the DWC IP. It is the target end of AXI4LITE_WRITE_BURST/READ_BURST traffic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte-address width; decodes 8 word slots.
- CNT_WIDTH, 16, width of the mismatch counter; must be 1..32.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset; synchronous, active-low.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake.
- mismatch_o  out  1  sticky mismatch flag.
- irq_o  out  1  mismatch_o AND CTRL.irq_en.

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge): all READY/VALID low; BRESP=RRESP=0; RDATA=0; all registers, counter and flags 0. Reset mid-transaction abandons it; no response is issued.
- Register map (word-aligned; addr[1:0] ignored):
  - 0x00 CTRL: R/W; bit0 cmp_en, bit1 clr (write-1 self-clearing, reads 0), bit2 irq_en.
  - 0x04 RES_A: R/W.
  - 0x08 RES_B: R/W.
  - 0x0C SCRATCH: R/W.
  - 0x10 MISCNT: RO, zero-extended.
  - 0x14 STATUS: RO; bit0 mismatch, bit1 last_cmp_equal.
  - 0x18, 0x1C: unmapped.
- Write channel (one outstanding write):
  - AWREADY is high while no address is latched and BVALID=0. WREADY is high while no data is latched and BVALID=0. AW and W may arrive in either order or in the same cycle.
  - The cycle after both are latched, the register update occurs and BVALID rises on the same edge. Minimum latency is 1 cycle from the later handshake to BVALID.
  - BVALID holds, with BRESP stable, until BREADY. After that both READYs may reassert the next cycle.
  - Byte lanes are updated only where WSTRB=1.
  - BRESP: OKAY for R/W slots; SLVERR for 0x10/0x14 (no state change); DECERR for unmapped (no state change).
- Read channel (one outstanding read):
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA/RRESP/RVALID are registered at the next edge and held until RREADY.
  - RRESP: OKAY for mapped slots; DECERR with RDATA=0 for unmapped.
  - A read sampled on the same edge as a write to the same register returns the pre-write value.
- Compare event: any completed write to RES_B while cmp_en=1 compares RES_A against the new RES_B (after WSTRB merge).
  - Unequal: mismatch<=1, last_cmp_equal<=0, MISCNT increments, saturating at 2^CNT_WIDTH-1.
  - Equal: last_cmp_equal<=1 only.
- Writes to RES_A never trigger a compare.
- A CTRL write with clr=1 zeroes MISCNT, mismatch and last_cmp_equal; the other CTRL bits take the written value. Clear and compare cannot coincide, since only one write is in flight.
- mismatch_o and irq_o are registered status bits; they update the cycle after the triggering write edge.

Decomposition:
- Package dwc_axil_pkg holds:
  - register offsets and CTRL/STATUS bit indices;
  - RESP_OKAY/SLVERR/DECERR localparams;
  - a typedef for the 3-bit slot index.
- One natural sub-module, dwc_cmp_unit: compare, saturating counter and sticky flag, driven by a write-strobe plus data. The AXI FSMs stay in the top level.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to 0x00..0x0C, then read back -> RDATA 0x1 (CTRL bit1 reads 0, so 0x1), 0x2, 0x3, 0x4; all RRESP=OKAY.
2. CTRL=0x5; RES_A=0xDEADBEEF; RES_B=0xDEADBEEE -> MISCNT=1, STATUS=0x1, mismatch_o=1, irq_o=1; then RES_B=0xDEADBEEF -> MISCNT=1, STATUS=0x3.
3. Write CTRL=0x3 -> MISCNT=0, STATUS=0, mismatch_o=0, CTRL reads 0x1.
4. Write 0x10 -> BRESP=SLVERR and MISCNT unchanged; read 0x18 -> RRESP=DECERR, RDATA=0.
5. W before AW by 3 cycles, and BREADY held low for 5 cycles -> BVALID held; AWREADY/WREADY stay low until the B handshake; WSTRB=0x3 write of 0xAABBCCDD onto 0x11223344 -> reads 0x1122CCDD.
6. Assert ARESETN=0 during a pending B with CTRL=0x5 and MISCNT=2 -> after release, all registers read 0 and no stale BVALID.
